cpu_io_port_responder: RTL

// Responder for the processor's 16-bit IN/OUT port. CPU OUT writes go into an output FIFO, drained by an external

---
 rtl/cpu_io_port_responder.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/cpu_io_port_responder.sv
`default_nettype none
// ============================================================================
// Module      : cpu_io_port_responder
// Description : CPU 16-bit IN/OUT port responder. OUT words go to a show-ahead
//               FIFO drained by a valid/ready consumer; IN words come from a
//               valid/ready producer through a 1-entry holding register.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_io_port_responder #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_out_we,
    input  logic [15:0]   cpu_out_data,
    input  logic          cpu_in_re,
    output logic [15:0]   cpu_in_data,
    output logic          cpu_in_valid,
    output logic          ext_out_valid,
    input  logic          ext_out_ready,
    output logic [15:0]   ext_out_data,
    input  logic          ext_in_valid,
    output logic          ext_in_ready,
    input  logic [15:0]   ext_in_data,
    output logic [AW:0]   out_count,
    output logic          out_full,
    output logic          ovf_flag,
    output logic          unf_flag,
    input  logic          clr_flags
);

    localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } hold_state_t;

    logic [15:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_ovf;
    logic          r_unf;
    logic [15:0]   r_hold;
    hold_state_t   r_state;

    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic          w_ovf_set;
    logic          w_unf_set;

    always_comb begin
        w_full    = (r_count == C_DEPTH);
        w_empty   = (r_count == '0);
        w_pop     = !w_empty && ext_out_ready;
        // A full FIFO still accepts a write when the head leaves in the same cycle.
        w_push    = cpu_out_we && (!w_full || w_pop);
        w_ovf_set = cpu_out_we && w_full && !w_pop;
        w_unf_set = cpu_in_re && (r_state == ST_EMPTY);
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= cpu_out_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_EMPTY;
            r_hold  <= 16'h0000;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (ext_in_valid) begin
                        r_hold  <= ext_in_data;
                        r_state <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (cpu_in_re) begin
                        r_state <= ST_EMPTY;
                    end
                end
                default: r_state <= ST_EMPTY;
            endcase
        end
    end

    // Setting a flag wins over a clear arriving in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (clr_flags) begin
                r_ovf <= 1'b0;
            end
            if (w_unf_set) begin
                r_unf <= 1'b1;
            end else if (clr_flags) begin
                r_unf <= 1'b0;
            end
        end
    end

    always_comb begin
        ext_out_valid = !w_empty;
        ext_out_data  = r_mem[r_rd_ptr];
        out_count     = r_count;
        out_full      = w_full;
        ovf_flag      = r_ovf;
        unf_flag      = r_unf;
        cpu_in_valid  = (r_state == ST_FULL);
        ext_in_ready  = (r_state == ST_EMPTY);
        cpu_in_data   = (r_state == ST_FULL) ? r_hold : 16'hFFFF;
    end

endmodule
`default_nettype wire
